cost_table: RTL
===============

COST_TABLE -- requirements
Module: cost_table

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port LoadValid, input, 1, LoadData carries one table entry this cycle.
REQ-004 SHALL have port LoadData, input, 7, entry value, written in row-major order {W,J} = 0..63.
REQ-005 SHALL have port Reload, input, 1, single-cycle pulse that discards the table and restarts loading.
REQ-006 SHALL have port W, input, 3, worker index of the lookup request.
REQ-007 SHALL have port J, input, 3, job index of the lookup request.
REQ-008 SHALL have port Cost, output, 7, registered lookup result.
REQ-009 SHALL have port Ready, output, 1, table is fully loaded and lookups are valid.
REQ-010 SHALL have port LoadErr, output, 1, sticky flag: LoadValid was asserted while in READY.

Function
REQ-011 SHALL implement the two-state FSM LOAD and READY; reset state LOAD.
REQ-012 In LOAD, each cycle with LoadValid=1 SHALL write LoadData to entry LoadIdx and increment the 6-bit LoadIdx.
REQ-013 A write with LoadIdx=63 SHALL move to READY; Ready SHALL be 1 from the following cycle; LoadIdx SHALL wrap to 0.
REQ-014 LoadValid=0 in LOAD SHALL hold LoadIdx; gaps of any length are allowed.
REQ-015 In READY, Cost SHALL be loaded each cycle from entry {W,J}, W as the high 3 bits; latency 1 cycle: W/J valid in cycle n give Cost in cycle n+1.
REQ-016 In LOAD, Cost SHALL be 0 whatever W/J are.
REQ-017 In READY, LoadValid=1 SHALL leave the table unchanged and set LoadErr; LoadErr clears only on RST or Reload.
REQ-018 Reload=1 in either state SHALL go to LOAD, clear LoadIdx, Ready, LoadErr, Cost next cycle.
REQ-019 If Reload and LoadValid occur in the same cycle, Reload SHALL win and LoadData SHALL be dropped.
REQ-020 The table SHALL be overwritten entry by entry on reload; entries not yet rewritten SHALL never be visible, because Cost=0 in LOAD.

Reset
REQ-021 RST SHALL force state=LOAD, LoadIdx=0, Cost=0, Ready=0, LoadErr=0.
REQ-022 Table contents SHALL NOT be reset; RST during LOAD aborts the load, and the next load restarts at entry 0.

Configuration
REQ-023 Macro COST_TABLE_ACCCNT_EN defined: the block SHALL add output port AccCount, 16 bits.
REQ-024 AccCount SHALL count cycles spent in READY (lookups served), saturate at 65535, and clear on RST or Reload.
REQ-025 Macro undefined: the block SHALL have no AccCount port and no counter logic, and all other behaviour SHALL be identical.

Structure
REQ-026 Package cost_table_pkg SHALL hold COST_W=7, IDX_W=3, ENTRIES=64, and the state enum {LOAD, READY}.
REQ-027 Sub-module cost_table_mem SHALL hold storage: 64x7 register file, 1 write port, 1 synchronous read port.
REQ-028 FSM, LoadIdx, flags, and the optional counter SHALL stay in cost_table.

Verification
REQ-029 Scenario: RST, then 64 writes of value (i*5)%128 back-to-back -> Ready=1 the cycle after write 63; W=2,J=3 -> next-cycle Cost=(19*5)%128=95.
REQ-030 Scenario: load with LoadValid toggling every other cycle -> Ready after exactly 64 accepted writes; entry 63 correct.
REQ-031 Scenario: in READY, W/J sweep 0..63 one per cycle -> Cost matches the model with a 1-cycle lag for all 64 entries.
REQ-032 Scenario: LoadValid=1 with LoadData=7 in READY -> LoadErr=1 and the entry at the old index unchanged; Reload -> LoadErr=0, Ready=0, Cost=0.
REQ-033 Scenario: Reload and LoadValid in the same cycle at LoadIdx=10 -> LoadIdx=0 and no write to entry 10.
REQ-034 Scenario: RST after 30 writes -> Ready=0; full 64-write reload gives correct lookups; with COST_TABLE_ACCCNT_EN, AccCount=N after N READY cycles.

Source files
------------

// File: rtl/cost_table_pkg.sv
// rtl/cost_table_pkg.sv - shared widths, sizes and FSM state for the cost lookup table
package cost_table_pkg;

  localparam int COST_W  = 7;
  localparam int IDX_W   = 3;
  localparam int ENTRIES = 64;
  localparam int ADDR_W  = 2 * IDX_W;
  localparam int ACC_W   = 16;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/cost_table_mem.sv
// rtl/cost_table_mem.sv - 64x7 register file, one write port, one synchronous read port
module cost_table_mem
  import cost_table_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [ENTRIES];

  // Storage is deliberately never reset; only the read register is cleared.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (rclr) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cost_table.sv
// rtl/cost_table.sv - loadable worker/job cost table with registered lookup
// Optional AccCount ready-cycle counter enabled by COST_TABLE_ACCCNT_EN.
module cost_table
  import cost_table_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              LoadValid,
  input  logic [COST_W-1:0] LoadData,
  input  logic              Reload,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic              Ready,
  output logic              LoadErr
`ifdef COST_TABLE_ACCCNT_EN
  ,
  output logic [ACC_W-1:0]  AccCount
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] load_idx;
  logic              restart;
  logic              we;
  logic              rclr;

  // Reload outranks a same-cycle LoadValid, so the write is gated here too.
  assign restart = RST || Reload;
  assign we      = (state == LOAD) && LoadValid && !restart;
  assign rclr    = restart || (state != READY);

  always_ff @(posedge CLK) begin
    if (restart) begin
      state    <= LOAD;
      load_idx <= '0;
      Ready    <= 1'b0;
      LoadErr  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (LoadValid) begin
            load_idx <= load_idx + ADDR_W'(1);
            if (load_idx == LAST_IDX) begin
              state <= READY;
              Ready <= 1'b1;
            end
          end
        end
        READY: begin
          if (LoadValid) begin
            LoadErr <= 1'b1;
          end
        end
        default: begin
          state <= LOAD;
          Ready <= 1'b0;
        end
      endcase
    end
  end

  cost_table_mem u_mem (
    .CLK   (CLK),
    .we    (we),
    .waddr (load_idx),
    .wdata (LoadData),
    .rclr  (rclr),
    .raddr ({W, J}),
    .rdata (Cost)
  );

`ifdef COST_TABLE_ACCCNT_EN
  always_ff @(posedge CLK) begin
    if (restart) begin
      AccCount <= '0;
    end else if ((state == READY) && (AccCount != ACC_MAX)) begin
      AccCount <= AccCount + ACC_W'(1);
    end
  end
`endif

endmodule
